// File: rtl/jpeg_pkg.sv
// Shared JPEG coder types: block size, channel index type
// and the MCU scheduler state encoding.
package jpeg_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int BEAT_W     = $clog2(BLOCK_SIZE);

  typedef logic [1:0] chan_t;

  typedef enum logic {
    IDLE,
    XFER
  } sched_state_t;

endpackage

// File: rtl/coef_out_reg.sv
// Single-entry valid/ready register carrying {data, chan, sob, eob}.
// Ports: load/ld_* in, out_ready in, out_* out, can_load out.
module coef_out_reg
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  chan_t                 ld_chan,
  input  logic                  ld_sob,
  input  logic                  ld_eob,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output chan_t                 out_chan,
  output logic                  out_sob,
  output logic                  out_eob,
  output logic                  can_load
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ld_data;
      out_chan  <= ld_chan;
      out_sob   <= ld_sob;
      out_eob   <= ld_eob;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mcu_scheduler.sv
// Grants one quantizer lane at a time to the entropy encoder in
// Y/Cb/Cr MCU order. Ports: start/frame_mcus, lane in_*, out_*, status.
module mcu_scheduler
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ROW        = 3,
  parameter int MCU_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MCU_W-1:0]          frame_mcus,
  input  logic [ROW-1:0]            in_valid,
  input  logic [ROW*DATA_WIDTH-1:0] in_data,
  output logic [ROW-1:0]            in_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  input  logic                      out_ready,
  output chan_t                     out_chan,
  output logic                      out_sob,
  output logic                      out_eob,
  output logic                      busy,
  output logic                      frame_done
);

  sched_state_t          state, state_nxt;
  chan_t                 cur_chan;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [MCU_W-1:0]      mcu_cnt;
  logic [MCU_W-1:0]      frame_len;
  logic                  can_load;
  logic                  grant;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;
  logic                  start_ok;
  logic                  last_beat;
  logic                  last_chan;
  logic                  last_mcu;

  assign busy      = (state == XFER) || out_valid;
  assign start_ok  = start && !busy && (frame_mcus != '0);
  assign grant     = (state == XFER) && can_load;
  assign xfer      = grant && sel_valid;
  assign last_beat = beat_cnt == BEAT_W'(BLOCK_SIZE - 1);
  assign last_chan = cur_chan == chan_t'(ROW - 1);
  assign last_mcu  = mcu_cnt == frame_len - MCU_W'(1);

  assign frame_done = xfer && last_beat
                   && last_chan && last_mcu;

  // Only the granted lane sees ready; others stall even if valid.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int i = 0; i < ROW; i++) begin
      if (cur_chan == chan_t'(i)) begin
        sel_valid   = in_valid[i];
        sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        in_ready[i] = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_ok)   state_nxt = XFER;
      XFER: if (frame_done) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_chan  <= '0;
      beat_cnt  <= '0;
      mcu_cnt   <= '0;
      frame_len <= '0;
    end else if (start_ok) begin
      cur_chan  <= '0;
      beat_cnt  <= '0;
      mcu_cnt   <= '0;
      frame_len <= frame_mcus;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
      if (last_beat) begin
        if (last_chan) begin
          cur_chan <= '0;
          mcu_cnt  <= mcu_cnt + MCU_W'(1);
        end else begin
          cur_chan <= cur_chan + chan_t'(1);
        end
      end
    end
  end

  coef_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (xfer),
    .ld_data  (sel_data),
    .ld_chan  (cur_chan),
    .ld_sob   (beat_cnt == '0),
    .ld_eob   (last_beat),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_sob  (out_sob),
    .out_eob  (out_eob),
    .can_load (can_load)
  );

endmodule

// File: tb/tb_mcu_scheduler.sv
// Randomized bench for mcu_scheduler against a frame-level
// reference model (expected beat queue built from lane order).
module tb_mcu_scheduler;
  import jpeg_pkg::*;

  localparam int DW  = 10;
  localparam int ROW = 3;
  localparam int MW  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [MW-1:0]     frame_mcus;
  logic [ROW-1:0]    in_valid;
  logic [ROW*DW-1:0] in_data;
  logic [ROW-1:0]    in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  chan_t             out_chan;
  logic              out_sob;
  logic              out_eob;
  logic              busy;
  logic              frame_done;

  always #5 clk = ~clk;

  mcu_scheduler #(
    .DATA_WIDTH(DW), .ROW(ROW), .MCU_W(MW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_mcus(frame_mcus),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .busy      (busy),
    .frame_done(frame_done)
  );

  typedef struct {
    int ch;
    int d;
    bit sob;
    bit eob;
  } beat_t;

  beat_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  int mode;
  bit tog;
  int stall_cnt;
  bit stall_used;
  bit start_req;
  int fm_req;
  bit active;
  int total;
  int in_cnt;
  int out_cnt;
  int done_cnt;
  int done_step;
  int step_no;
  bit first_chk;
  bit prev_hold;
  int prev_d;
  bit mid_start_done;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    start      = start_req;
    frame_mcus = MW'(fm_req);
    start_req  = 1'b0;
    for (int l = 0; l < ROW; l++)
      in_data[l*DW +: DW] = DW'($urandom);
    unique case (mode)
      1: begin
        in_valid  = '1;
        out_ready = tog;
        tog       = !tog;
      end
      2: begin
        for (int l = 0; l < ROW; l++)
          in_valid[l] = ($urandom % 3) != 0;
        out_ready = ($urandom % 4) != 0;
      end
      3: begin
        if (active && !stall_used && in_cnt == 64) begin
          stall_cnt  = 50;
          stall_used = 1'b1;
        end
        in_valid    = '1;
        in_valid[1] = stall_cnt == 0;
        if (stall_cnt > 0) stall_cnt--;
        out_ready = 1'b1;
      end
      default: begin
        in_valid  = '1;
        out_ready = 1'b1;
      end
    endcase
  endtask

  task automatic monitor();
    int  el;
    bit  xf;
    beat_t b;
    if (prev_hold) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), prev_d);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_out", 1, 0);
      end else begin
        b = exp_q.pop_front();
        chk("out_chan", int'(out_chan), b.ch);
        chk("out_data", int'(out_data), b.d);
        chk("out_sob", int'(out_sob), int'(b.sob));
        chk("out_eob", int'(out_eob), int'(b.eob));
        out_cnt++;
      end
    end
    xf = 1'b0;
    if (first_chk) begin
      chk("rdy0_after_start", int'(in_ready[0]), 1);
      first_chk = 1'b0;
    end
    if (active) begin
      el = (in_cnt / 64) % ROW;
      chk("rdy_other",
          int'(in_ready & ~(ROW'(1) << el)), 0);
      chk("rdy_lane", int'(in_ready[el]),
          int'(!out_valid || out_ready));
      xf = in_valid[el] && in_ready[el];
      chk("frame_done", int'(frame_done),
          int'(xf && in_cnt == total - 1));
      if (xf) begin
        b.ch  = el;
        b.d   = int'(in_data[el*DW +: DW]);
        b.sob = (in_cnt % 64) == 0;
        b.eob = (in_cnt % 64) == 63;
        exp_q.push_back(b);
        in_cnt++;
        if (in_cnt == total) active = 1'b0;
      end
    end else begin
      chk("rdy_idle", int'(in_ready), 0);
      chk("done_idle", int'(frame_done), 0);
    end
    if (frame_done) begin
      done_cnt++;
      done_step = step_no;
    end
    prev_hold = out_valid && !out_ready;
    prev_d    = int'(out_data);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic run_frame(int mcus, int m, int abort_at);
    int s0;
    int guard;
    mode = m;
    stall_used = 1'b0;
    stall_cnt  = 0;
    mid_start_done = 1'b0;
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 200) begin
      step();
      guard++;
    end
    start_req = 1'b1;
    fm_req    = mcus;
    step();
    s0        = step_no;
    active    = 1'b1;
    total     = 192 * mcus;
    in_cnt    = 0;
    out_cnt   = 0;
    done_cnt  = 0;
    done_step = 0;
    first_chk = 1'b1;
    guard     = 0;
    while ((active || exp_q.size() != 0) && guard < 20000) begin
      if (abort_at >= 0 && in_cnt == abort_at) return;
      if (m == 1 && in_cnt == 100 && !mid_start_done) begin
        start_req = 1'b1;
        fm_req    = 5;
        mid_start_done = 1'b1;
      end
      step();
      guard++;
    end
    chk("timeout", int'(guard >= 20000), 0);
    chk("beats_out", out_cnt, total);
    chk("done_count", done_cnt, 1);
    if (m == 0) chk("frame_cycles", done_step - s0, total);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_no++;
    exp_q.delete();
    active    = 1'b0;
    prev_hold = 1'b0;
    first_chk = 1'b0;
    in_cnt    = 0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_sob_eob", int'({out_sob, out_eob}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_frame_done", int'(frame_done), 0);
  endtask

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    frame_mcus = '0;
    in_valid   = '0;
    in_data    = '0;
    out_ready  = 1'b1;
    tog        = 1'b1;
    start_req  = 1'b0;
    fm_req     = 0;
    mode       = 0;
    step_no    = 0;
    prev_hold  = 1'b0;
    first_chk  = 1'b0;
    active     = 1'b0;
    do_reset();

    start_req = 1'b1;
    fm_req    = 0;
    mode      = 0;
    step();
    step();
    chk("zero_start_busy", int'(busy), 0);
    chk("zero_start_rdy", int'(in_ready), 0);

    run_frame(1, 0, -1);
    run_frame(2, 1, -1);
    run_frame(1, 3, -1);
    run_frame(3, 2, -1);
    run_frame(1, 0, 64 + 30);
    do_reset();
    run_frame(1, 0, -1);
    run_frame(2, 2, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
